// File: rtl/mips_multicycle_io.sv
// mips_multicycle_io: multicycle MIPS core with one unified memory port and a memory-mapped I/O window.
// Optional build macro MIPS_IO_HANDSHAKE_EN: I/O accesses stall until IOReady is seen at a clock edge.
module mips_multicycle_io #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter logic [31:0] IO_BASE  = 32'h0000_7FF0,
    parameter int          IO_AW    = 4
) (
    input  logic             CLK,
    input  logic             RESET,
    output logic [31:0]      MemAddr,
    output logic [31:0]      MemWriteData,
    output logic             MemWriteEn,
    input  logic [31:0]      MemReadData,
    output logic [IO_AW-1:0] IOAddr,
    output logic [31:0]      IOWriteData,
    output logic             IOWriteEn,
    output logic             IOReadEn,
    input  logic [31:0]      IOReadData,
    input  logic             IOReady,
    output logic             Halted
);
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXECUTE, S_ALUWB, S_ADDIEX, S_ADDIWB, S_BRANCH, S_JUMP, S_HALT
    } state_t;

    state_t      state_reg, state_next;
    logic [31:0] pc_reg, ir_reg, a_reg, b_reg, alu_out_reg, mdr_reg;
    logic [31:0] rf [0:31];

    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd;
    logic [31:0] sign_imm, rs_val, rt_val, alu_result;
    logic        funct_ok, io_hit, io_wait;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    assign opcode   = ir_reg[31:26];
    assign rs       = ir_reg[25:21];
    assign rt       = ir_reg[20:16];
    assign rd       = ir_reg[15:11];
    assign funct    = ir_reg[5:0];
    assign sign_imm = {{16{ir_reg[15]}}, ir_reg[15:0]};
    assign rs_val   = (rs == 5'd0) ? 32'd0 : rf[rs];
    assign rt_val   = (rt == 5'd0) ? 32'd0 : rf[rt];
    assign io_hit   = (alu_out_reg[31:IO_AW] == IO_BASE[31:IO_AW]);

`ifdef MIPS_IO_HANDSHAKE_EN
    assign io_wait = io_hit && !IOReady;
`else
    logic unused_io_ready;
    assign unused_io_ready = IOReady;
    assign io_wait         = 1'b0;
`endif

    always_comb begin
        funct_ok   = 1'b1;
        alu_result = 32'd0;
        case (funct)
            6'h20:   alu_result = a_reg + b_reg;
            6'h22:   alu_result = a_reg - b_reg;
            6'h24:   alu_result = a_reg & b_reg;
            6'h25:   alu_result = a_reg | b_reg;
            6'h2A:   alu_result = {31'd0, $signed(a_reg) < $signed(b_reg)};
            default: funct_ok = 1'b0;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) state_reg <= S_FETCH;
        else       state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_FETCH:    state_next = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE:     state_next = funct_ok ? S_EXECUTE : S_HALT;
                    OP_LW, OP_SW: state_next = S_MEMADR;
                    OP_BEQ:       state_next = S_BRANCH;
                    OP_ADDI:      state_next = S_ADDIEX;
                    OP_J:         state_next = S_JUMP;
                    default:      state_next = S_HALT;
                endcase
            end
            S_MEMADR:   state_next = (opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  state_next = io_wait ? S_MEMREAD : S_MEMWB;
            S_MEMWRITE: state_next = io_wait ? S_MEMWRITE : S_FETCH;
            S_EXECUTE:  state_next = S_ALUWB;
            S_ADDIEX:   state_next = S_ADDIWB;
            S_HALT:     state_next = S_HALT;
            default:    state_next = S_FETCH;
        endcase
    end

    always_comb begin
        MemAddr    = (state_reg == S_FETCH) ? pc_reg : alu_out_reg;
        MemWriteEn = (state_reg == S_MEMWRITE) && !io_hit;
        IOWriteEn  = (state_reg == S_MEMWRITE) && io_hit;
        IOReadEn   = (state_reg == S_MEMREAD) && io_hit;
        Halted     = (state_reg == S_HALT);
        rf_we      = 1'b0;
        rf_waddr   = rt;
        rf_wdata   = alu_out_reg;
        case (state_reg)
            S_MEMWB:  begin rf_we = 1'b1; rf_wdata = mdr_reg; end
            S_ALUWB:  begin rf_we = 1'b1; rf_waddr = rd; end
            S_ADDIWB: rf_we = 1'b1;
            default:  rf_we = 1'b0;
        endcase
    end

    assign MemWriteData = b_reg;
    assign IOWriteData  = b_reg;
    assign IOAddr       = MemAddr[IO_AW-1:0];

    // DECODE precomputes the branch target; PC already points at the next instruction.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            pc_reg      <= RESET_PC;
            ir_reg      <= 32'd0;
            a_reg       <= 32'd0;
            b_reg       <= 32'd0;
            alu_out_reg <= 32'd0;
            mdr_reg     <= 32'd0;
        end else begin
            case (state_reg)
                S_FETCH: begin
                    ir_reg <= MemReadData;
                    pc_reg <= pc_reg + 32'd4;
                end
                S_DECODE: begin
                    a_reg       <= rs_val;
                    b_reg       <= rt_val;
                    alu_out_reg <= pc_reg + {sign_imm[29:0], 2'b00};
                end
                S_MEMADR, S_ADDIEX: alu_out_reg <= a_reg + sign_imm;
                S_MEMREAD: mdr_reg <= io_hit ? IOReadData : MemReadData;
                S_EXECUTE: alu_out_reg <= alu_result;
                S_BRANCH:  if (a_reg == b_reg) pc_reg <= alu_out_reg;
                S_JUMP:    pc_reg <= {pc_reg[31:28], ir_reg[25:0], 2'b00};
                default:   ;
            endcase
        end
    end

    // The write state is cleared asynchronously by RESET, so an aborted instruction never commits.
    always_ff @(posedge CLK) begin
        if (rf_we && rf_waddr != 5'd0) rf[rf_waddr] <= rf_wdata;
    end
endmodule

// File: tb/tb_mips_multicycle_io.sv
// tb_mips_multicycle_io: ISA-level model predicts per-cycle bus activity; literal checks pin key cycles.
module tb_mips_multicycle_io;
    logic        CLK, RESET;
    logic [31:0] MemAddr, MemWriteData, MemReadData, IOWriteData, IOReadData;
    logic        MemWriteEn, IOWriteEn, IOReadEn, IOReady, Halted;
    logic [3:0]  IOAddr;

    mips_multicycle_io dut (
        .CLK(CLK), .RESET(RESET),
        .MemAddr(MemAddr), .MemWriteData(MemWriteData), .MemWriteEn(MemWriteEn),
        .MemReadData(MemReadData),
        .IOAddr(IOAddr), .IOWriteData(IOWriteData), .IOWriteEn(IOWriteEn),
        .IOReadEn(IOReadEn), .IOReadData(IOReadData), .IOReady(IOReady),
        .Halted(Halted)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Unified RAM and a constant-valued I/O device.
    logic [31:0] ram [0:4095];
    assign MemReadData = ram[MemAddr[13:2]];
    assign IOReadData  = 32'hA5A5_A5A5;
    always @(posedge CLK) if (MemWriteEn) ram[MemAddr[13:2]] <= MemWriteData;

    typedef struct {
        logic        chk_addr;
        logic [31:0] addr;
        logic        mwe, iowe, iore, halted, chk_wd;
        logic [31:0] wd;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] m_mem [0:4095];
    logic [31:0] m_regs [0:31];
    logic [31:0] m_pc;
    logic        m_halted;

    int n_pass = 0, n_total = 0, cyc = 0;
    logic chk_on = 1'b0;
    logic [31:0] log_addr [0:127];
    logic [31:0] log_wd [0:127];
    logic [3:0]  log_ioaddr [0:127];
    logic        log_mwe [0:127], log_iowe [0:127], log_iore [0:127], log_halt [0:127];

    function automatic logic is_io(input logic [31:0] a);
        return (a & 32'hFFFF_FFF0) == 32'h0000_7FF0;
    endfunction

    task automatic push(input logic ca, input logic [31:0] ad, input logic mw, input logic iw,
                        input logic ir, input logic hl, input logic cw, input logic [31:0] wd);
        exp_t r;
        r.chk_addr = ca; r.addr = ad; r.mwe = mw; r.iowe = iw; r.iore = ir;
        r.halted = hl; r.chk_wd = cw; r.wd = wd;
        exp_q.push_back(r);
    endtask

    task automatic plain();
        push(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    endtask

    task automatic wr(input logic [4:0] r, input logic [31:0] v);
        if (r != 5'd0) m_regs[r] = v;
    endtask

    // One instruction of architectural behaviour, expanded into its expected bus cycles.
    task automatic gen_instr();
        logic [31:0] ins, pc4, simm, va, vb, res, ea;
        logic [5:0]  op;
        logic        bad;
        if (m_halted) begin
            push(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
            return;
        end
        ins  = m_mem[m_pc[13:2]];
        push(1'b1, m_pc, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        plain();
        pc4  = m_pc + 32'd4;
        m_pc = pc4;
        op   = ins[31:26];
        simm = {{16{ins[15]}}, ins[15:0]};
        va   = m_regs[ins[25:21]];
        vb   = m_regs[ins[20:16]];
        ea   = va + simm;
        bad  = 1'b0;
        res  = 32'd0;
        case (op)
            6'h00: begin
                case (ins[5:0])
                    6'h20:   res = va + vb;
                    6'h22:   res = va - vb;
                    6'h24:   res = va & vb;
                    6'h25:   res = va | vb;
                    6'h2A:   res = ($signed(va) < $signed(vb)) ? 32'd1 : 32'd0;
                    default: bad = 1'b1;
                endcase
                if (bad) m_halted = 1'b1;
                else begin plain(); plain(); wr(ins[15:11], res); end
            end
            6'h08: begin plain(); plain(); wr(ins[20:16], ea); end
            6'h23: begin
                plain();
                push(1'b1, ea, 1'b0, 1'b0, is_io(ea), 1'b0, 1'b0, 32'd0);
                plain();
                wr(ins[20:16], is_io(ea) ? IOReadData : m_mem[ea[13:2]]);
            end
            6'h2B: begin
                plain();
                push(1'b1, ea, !is_io(ea), is_io(ea), 1'b0, 1'b0, 1'b1, vb);
                if (!is_io(ea)) m_mem[ea[13:2]] = vb;
            end
            6'h04: begin plain(); if (va == vb) m_pc = pc4 + (simm << 2); end
            6'h02: begin plain(); m_pc = {pc4[31:28], ins[25:0], 2'b00}; end
            default: m_halted = 1'b1;
        endcase
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_total++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %h, expected %h", nm, got, want);
    endtask

    // Releases reset between a rising edge and the following sample, so the next sample is cycle 0.
    task automatic do_reset();
        RESET = 1'b1;
        repeat (2) @(posedge CLK);
        #2;
        RESET    = 1'b0;
        m_pc     = 32'h0000_3000;
        m_halted = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 4096; i++) m_mem[i] = ram[i];
        cyc = 0;
    endtask

    task automatic run_cycles(input int n);
        while (exp_q.size() < n) gen_instr();
        chk_on = 1'b1;
        repeat (n) @(negedge CLK);
        #1;
        chk_on = 1'b0;
    endtask

    exp_t cmp_e;
    logic cmp_ok;
    always @(negedge CLK) begin
        if (chk_on) begin
            if (cyc < 128) begin
                log_addr[cyc] = MemAddr;   log_wd[cyc]   = MemWriteData;
                log_mwe[cyc]  = MemWriteEn; log_iowe[cyc] = IOWriteEn;
                log_iore[cyc] = IOReadEn;  log_halt[cyc] = Halted;
                log_ioaddr[cyc] = IOAddr;
            end
            n_total++;
            if (exp_q.size() == 0) begin
                $display("FAIL cycle %0d: model has no expectation left", cyc);
            end else begin
                cmp_e  = exp_q.pop_front();
                cmp_ok = (MemWriteEn === cmp_e.mwe) && (IOWriteEn === cmp_e.iowe) &&
                         (IOReadEn === cmp_e.iore) && (Halted === cmp_e.halted) &&
                         (!cmp_e.chk_addr || (MemAddr === cmp_e.addr && IOAddr === cmp_e.addr[3:0])) &&
                         (!cmp_e.chk_wd || (MemWriteData === cmp_e.wd && IOWriteData === cmp_e.wd));
                if (cmp_ok) n_pass++;
                else $display("FAIL cycle %0d: got addr=%h we=%b iowe=%b iore=%b halt=%b wd=%h, expected addr=%h we=%b iowe=%b iore=%b halt=%b wd=%h",
                              cyc, MemAddr, MemWriteEn, IOWriteEn, IOReadEn, Halted, MemWriteData,
                              cmp_e.addr, cmp_e.mwe, cmp_e.iowe, cmp_e.iore, cmp_e.halted, cmp_e.wd);
            end
            cyc++;
        end
    end

    logic [31:0] prog_a [0:20];
    int          hs_cnt;
    logic        hs_we [0:9];
    logic [31:0] hs_addr [0:9];

    initial begin
        prog_a = '{32'h20020005, 32'h20030007, 32'h00432020, 32'hAC040010,
                   32'h20057FF4, 32'hACA40000, 32'h8CA60000, 32'hAC060020,
                   32'h00C43822, 32'h00C4402A, 32'h00C74824, 32'h00875025,
                   32'hAC070024, 32'hAC080028, 32'hAC09002C, 32'hAC0A0030,
                   32'h10000001, 32'hFC000000, 32'h08000C14, 32'hFC000000,
                   32'h1000FFFF};
        for (int i = 0; i < 4096; i++) ram[i] = 32'd0;
        for (int i = 0; i < 21; i++) ram[12'hC00 + i] = prog_a[i];
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        IOReady = 1'b1;
        RESET   = 1'b1;

        // Reset state
        @(posedge CLK); #1;
        chk("reset_memaddr", MemAddr, 32'h0000_3000);
        chk("reset_halted", 32'(Halted), 32'd0);
        chk("reset_strobes", {29'd0, MemWriteEn, IOWriteEn, IOReadEn}, 32'd0);

        // Program A: arithmetic, memory and I/O stores/loads, branches, jump, tight loop
        do_reset();
        run_cycles(83);
        chk("a_pc_after_first", log_addr[4], 32'h0000_3004);
        chk("a_sw_we", 32'(log_mwe[15]), 32'd1);
        chk("a_sw_addr", log_addr[15], 32'h0000_0010);
        chk("a_sw_data", log_wd[15], 32'd12);
        chk("a_sw_one_cycle", {30'd0, log_mwe[14], log_mwe[16]}, 32'd0);
        chk("a_next_fetch", log_addr[16], 32'h0000_3010);
        chk("a_io_we", {30'd0, log_iowe[23], log_mwe[23]}, 32'd2);
        chk("a_io_addr", 32'(log_ioaddr[23]), 32'd4);
        chk("a_io_data", log_wd[23], 32'd12);
        chk("a_io_re", 32'(log_iore[27]), 32'd1);
        chk("a_ram_lw_io", ram[8], 32'hA5A5_A5A5);
        chk("a_ram_sub", ram[9], 32'hA5A5_A599);
        chk("a_ram_slt", ram[10], 32'd1);
        chk("a_ram_and", ram[11], 32'hA5A5_A581);
        chk("a_ram_or", ram[12], 32'hA5A5_A59D);
        chk("a_loop_71", log_addr[71], 32'h0000_3050);
        chk("a_loop_74", log_addr[74], 32'h0000_3050);
        chk("a_loop_77", log_addr[77], 32'h0000_3050);

        // Reset while the first store is strobing
        ram[4] = 32'd0;
        do_reset();
        run_cycles(15);
        @(negedge CLK); #1;
        chk("b_we_before_reset", 32'(MemWriteEn), 32'd1);
        RESET = 1'b1;
        #1;
        chk("b_we_async_drop", 32'(MemWriteEn), 32'd0);
        chk("b_addr_async", MemAddr, 32'h0000_3000);
        @(posedge CLK); #1;
        chk("b_store_aborted", ram[4], 32'd0);

        // Unsupported opcode halts, reset clears it
        ram[12'hC00] = 32'hFC00_0000;
        do_reset();
        run_cycles(6);
        chk("c_halt_decode", 32'(log_halt[1]), 32'd0);
        chk("c_halt_set", 32'(log_halt[2]), 32'd1);
        RESET = 1'b1;
        #1;
        chk("c_halt_cleared", 32'(Halted), 32'd0);
        chk("c_pc_reset", MemAddr, 32'h0000_3000);

        // Unsupported funct halts too
        ram[12'hC00] = 32'h0000_003F;
        do_reset();
        run_cycles(4);
        chk("c_funct_halt", 32'(log_halt[2]), 32'd1);

        // Jump to RESET_PC
        ram[12'hC00] = 32'h0800_0C00;
        do_reset();
        run_cycles(7);
        chk("d_jump_fetch", log_addr[3], 32'h0000_3000);
        chk("d_jump_again", log_addr[6], 32'h0000_3000);

`ifdef MIPS_IO_HANDSHAKE_EN
        // I/O store stalled by IOReady, then reset during the stall
        ram[12'hC00] = 32'hACA4_0000;
        ram[12'hC01] = 32'h1000_FFFF;
        IOReady = 1'b0;
        do_reset();
        hs_cnt = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge CLK); #1;
            hs_we[k]   = IOWriteEn;
            hs_addr[k] = MemAddr;
            if (IOWriteEn) hs_cnt++;
            if (k == 6) IOReady = 1'b1;
        end
        chk("e_iowe_cycles", 32'(hs_cnt), 32'd4);
        chk("e_iowe_start", {30'd0, hs_we[2], hs_we[3]}, 32'd1);
        chk("e_io_addr_held", hs_addr[6], 32'h0000_7FF4);
        chk("e_next_fetch", hs_addr[7], 32'h0000_3004);
        IOReady = 1'b0;
        do_reset();
        repeat (5) @(negedge CLK);
        #1;
        chk("e_iowe_waiting", 32'(IOWriteEn), 32'd1);
        RESET = 1'b1;
        #1;
        chk("e_iowe_async_drop", 32'(IOWriteEn), 32'd0);
        IOReady = 1'b1;
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
